banked_sdpram_sync: RTL and testbench
=====================================

# banked_sdpram_sync

Parametrised successor to the decoder's single-lane simple dual-port RAM. It stores NB lanes of W-bit LLR words per address, with one shared write port and one shared read port, a registered one-cycle read and per-lane write enables. After every reset it runs a self-clearing sweep that zeroes all MEMDEPTH locations before accepting traffic. It sits between the layer processing units and the column/posterior memories, where several circulant lanes are accessed in lockstep.

## Interface
- W, 6, bits per lane word
- NB, 4, lanes (banks) per address
- ADDRESSWIDTH, 9, address bits
- MEMDEPTH, 511, valid locations; legal range is 1 ≤ MEMDEPTH ≤ 2^ADDRESSWIDTH
- memclk  input  1  sole clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous and active-high
- RA  input  ADDRESSWIDTH  read address
- rd_in  input  1  read request
- DIN  input  NB*W  write data; lane i occupies bits [i*W +: W]
- WA  input  ADDRESSWIDTH  write address
- wr_in  input  NB  per-lane write enable
- DOUT  output  NB*W  registered read data
- rd_valid  output  1  DOUT holds a completed read
- ready  output  1  init sweep done; requests are accepted

## Operation
- FSM states are INIT and READY. rst forces INIT and sets the sweep counter to 0.
- INIT: each edge writes 0 to all lanes at the counter address, then increments the counter.
  - After the edge that clears address MEMDEPTH-1, the FSM moves to READY.
  - rd_in and wr_in are ignored in INIT; rd_valid stays 0.
- READY, write: on an edge with wr_in[i]=1 and WA < MEMDEPTH, lane i at WA takes DIN lane i. Other lanes are unchanged.
- READY, read: on an edge with rd_in=1, DOUT takes the word at RA and rd_valid goes to 1.
  - If RA ≥ MEMDEPTH, DOUT takes all zeros and rd_valid still goes to 1.
- On an edge with rd_in=0, DOUT returns to 0 and rd_valid to 0. This keeps the legacy "no read gives zero output" contract.
- Out-of-range writes (WA ≥ MEMDEPTH) are dropped silently.
- Same-address read and write on one edge: the result is set by the configuration macro (see Configuration).
- The FSM never leaves READY except through rst.

## Timing
- Reset values: DOUT=0, rd_valid=0, ready=0, FSM=INIT, counter=0. These apply immediately on rst assertion, with no clock needed.
- Array contents are not reset directly; the sweep clears them.
- Sweep length: the first memclk edge with rst low clears address 0. ready is 1 after exactly MEMDEPTH edges.
- Read latency is 1 cycle: a request sampled at edge n is visible on DOUT and rd_valid after edge n.
- Write latency is 1 cycle: data written at edge n is readable by a request sampled at edge n+1.
- Throughput is one read and one write per cycle, sustained.
- rst asserted mid-sweep or mid-traffic: the sweep restarts from address 0 after release, and any in-flight read is discarded.

## Configuration
- Macro: SDPRAM_BYPASS_EN.
- Defined (write-first): on a same-address collision (rd_in=1, wr_in[i]=1, RA==WA < MEMDEPTH), DOUT lane i takes DIN lane i. Lanes without wr_in set return stored data.
- Undefined (read-first): DOUT returns the pre-write contents on a collision. The new data is visible from the next read.

## Structure
- Shared package ldpc_mem_pkg holds:
  - the FSM state encoding (INIT/READY localparams)
  - the default W, NB, ADDRESSWIDTH and MEMDEPTH constants
  - the lane-slice helper used by all banked memories
- One sub-module, sdpram_lane: a single W×MEMDEPTH array with write enable, registered read and the optional bypass.
  - It is instantiated NB times via generate.
  - The top holds the FSM, sweep counter, range checks and rd_valid.

## Test plan
- Reset, then release with MEMDEPTH=16 → ready=0 for 15 edges and ready=1 after the 16th. Reading every address then returns 0 with rd_valid=1.
- Write DIN=0x3F_2A_15_01 to WA=5 with wr_in=4'b1111, then read RA=5 next cycle → DOUT=0x3F2A1501 one cycle after the read request.
- Write 0x3F to all lanes at address 3, then write 0x00 with wr_in=4'b0101 → DOUT=0x3F003F00.
- Same-cycle collision: RA=WA=7, old data 0x11 per lane, DIN 0x22 per lane. With SDPRAM_BYPASS_EN → DOUT=0x22 per lane; without → 0x11, then 0x22 on the next read.
- With MEMDEPTH=16, write to WA=20, then read RA=20 → no array change and DOUT=0 with rd_valid=1.
- Assert rst for one cycle at sweep address 8 after address 2 was written in the prior READY phase → the sweep restarts at 0 and address 2 reads 0 once ready=1.

Source files
------------

// File: rtl/ldpc_mem_pkg.sv
// rtl/ldpc_mem_pkg.sv - shared state encoding, default sizes and lane-slice helper for banked decoder memories
package ldpc_mem_pkg;

  localparam int W_DEF        = 6;
  localparam int NB_DEF       = 4;
  localparam int AW_DEF       = 9;
  localparam int MEMDEPTH_DEF = 511;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // LSB position of lane `lane` in a packed multi-lane word of `w`-bit lanes
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/sdpram_lane.sv
// rtl/sdpram_lane.sv - one W x DEPTH simple dual-port lane, registered read, write-first bypass under SDPRAM_BYPASS_EN
module sdpram_lane #(
  parameter int W     = 6,
  parameter int DEPTH = 511,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  // Callers only assert we/re for in-range addresses, so the truncated index is safe
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (re) begin
      rdata_d = mem_q[raddr[IW-1:0]];
`ifdef SDPRAM_BYPASS_EN
      if (we && (waddr == raddr)) begin
        rdata_d = wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_sdpram_sync.sv
// rtl/banked_sdpram_sync.sv - NB-lane banked SDP RAM with self-clearing init sweep; collision bypass via SDPRAM_BYPASS_EN
module banked_sdpram_sync
  import ldpc_mem_pkg::*;
#(
  parameter int W            = W_DEF,
  parameter int NB           = NB_DEF,
  parameter int ADDRESSWIDTH = AW_DEF,
  parameter int MEMDEPTH     = MEMDEPTH_DEF
) (
  input  logic                    memclk,
  input  logic                    rst,
  input  logic [ADDRESSWIDTH-1:0] RA,
  input  logic                    rd_in,
  input  logic [NB*W-1:0]         DIN,
  input  logic [ADDRESSWIDTH-1:0] WA,
  input  logic [NB-1:0]           wr_in,
  output logic [NB*W-1:0]         DOUT,
  output logic                    rd_valid,
  output logic                    ready
);

  localparam logic [ADDRESSWIDTH:0]   DEPTH_C = (ADDRESSWIDTH+1)'(MEMDEPTH);
  localparam logic [ADDRESSWIDTH-1:0] LAST_C  = ADDRESSWIDTH'(MEMDEPTH - 1);

  mem_state_e              state_q, state_d;
  logic [ADDRESSWIDTH-1:0] cnt_q, cnt_d;
  logic                    rd_valid_q, rd_valid_d;

  logic                    sweeping;
  logic                    wa_ok, ra_ok, rd_hit;
  logic [ADDRESSWIDTH-1:0] lane_waddr;

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = READY;
        end
      end
      READY: begin
        rd_valid_d = rd_in;
      end
      default: state_d = INIT;
    endcase
  end

  assign sweeping   = (state_q == INIT);
  assign wa_ok      = ({1'b0, WA} < DEPTH_C);
  assign ra_ok      = ({1'b0, RA} < DEPTH_C);
  // Out-of-range reads still raise rd_valid but leave every lane register at zero
  assign rd_hit     = !sweeping && rd_in && ra_ok;
  assign lane_waddr = sweeping ? cnt_q : WA;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic         lane_we;
    logic [W-1:0] lane_wdata;

    assign lane_we    = sweeping || (wr_in[g] && wa_ok);
    assign lane_wdata = sweeping ? '0 : DIN[lane_lsb(g, W) +: W];

    sdpram_lane #(
      .W     (W),
      .DEPTH (MEMDEPTH),
      .AW    (ADDRESSWIDTH)
    ) u_lane (
      .clk   (memclk),
      .rst   (rst),
      .we    (lane_we),
      .waddr (lane_waddr),
      .wdata (lane_wdata),
      .re    (rd_hit),
      .raddr (RA),
      .rdata (DOUT[lane_lsb(g, W) +: W])
    );
  end

  assign rd_valid = rd_valid_q;
  assign ready    = (state_q == READY);

endmodule

// File: tb/tb_banked_sdpram_sync.sv
// tb/tb_banked_sdpram_sync.sv - scoreboard bench for banked_sdpram_sync (MEMDEPTH=16), aware of SDPRAM_BYPASS_EN
module tb_banked_sdpram_sync;

  localparam int W   = 6;
  localparam int NB  = 4;
  localparam int AW  = 9;
  localparam int DEP = 16;

  logic          memclk = 1'b0;
  logic          rst    = 1'b1;
  logic [AW-1:0] RA     = '0;
  logic          rd_in  = 1'b0;
  logic [23:0]   DIN    = '0;
  logic [AW-1:0] WA     = '0;
  logic [NB-1:0] wr_in  = '0;
  logic [23:0]   DOUT;
  logic          rd_valid;
  logic          ready;

  int n_total = 0;
  int n_pass  = 0;
  logic [23:0] exp_q [$];

  banked_sdpram_sync #(
    .W(W), .NB(NB), .ADDRESSWIDTH(AW), .MEMDEPTH(DEP)
  ) dut (
    .memclk  (memclk),
    .rst     (rst),
    .RA      (RA),
    .rd_in   (rd_in),
    .DIN     (DIN),
    .WA      (WA),
    .wr_in   (wr_in),
    .DOUT    (DOUT),
    .rd_valid(rd_valid),
    .ready   (ready)
  );

  always #5 memclk = ~memclk;

  function automatic logic [23:0] pk(input logic [5:0] l3, input logic [5:0] l2,
                                     input logic [5:0] l1, input logic [5:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  // Monitor: compares every presented read against the scoreboard head
  always @(posedge memclk) begin
    #2;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        chk("read_data", 32'(DOUT), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("idle_dout_zero", 32'(DOUT), 32'd0);
    end
  end

  task automatic cyc(input logic rd, input logic [AW-1:0] ra, input logic [3:0] wr,
                     input logic [AW-1:0] wa, input logic [23:0] din, input logic [23:0] exp_v);
    rd_in = rd; RA = ra; wr_in = wr; WA = wa; DIN = din;
    if (rd) exp_q.push_back(exp_v);
    @(posedge memclk); #1;
    rd_in = 1'b0; wr_in = '0;
  endtask

  task automatic sweep_check(input int edges, input string name);
    for (int i = 1; i <= edges; i++) begin
      @(posedge memclk); #1;
      chk(name, 32'(ready), (i == DEP) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [23:0] c11, c22, m9;
    c11 = pk(6'h11, 6'h11, 6'h11, 6'h11);
    c22 = pk(6'h22, 6'h22, 6'h22, 6'h22);
    m9  = pk(6'h11, 6'h11, 6'h22, 6'h22);

    #3;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_dout", 32'(DOUT), 32'd0);
    @(posedge memclk); #1;
    // Traffic during the sweep must be ignored
    rd_in = 1'b1; RA = 9'd3; wr_in = 4'hF; WA = 9'd3; DIN = c22;
    rst = 1'b0;
    sweep_check(DEP, "sweep_ready");
    rd_in = 1'b0; wr_in = '0;

    for (int a = 0; a < DEP; a++) cyc(1'b1, AW'(a), 4'h0, '0, '0, 24'h0);

    cyc(1'b0, '0, 4'hF, 9'd5, pk(6'h3F, 6'h2A, 6'h15, 6'h01), 24'h0);
    cyc(1'b1, 9'd5, 4'h0, '0, '0, pk(6'h3F, 6'h2A, 6'h15, 6'h01));

    cyc(1'b0, '0, 4'hF, 9'd3, pk(6'h3F, 6'h3F, 6'h3F, 6'h3F), 24'h0);
    cyc(1'b0, '0, 4'b0101, 9'd3, 24'h0, 24'h0);
    cyc(1'b1, 9'd3, 4'h0, '0, '0, pk(6'h3F, 6'h00, 6'h3F, 6'h00));

    cyc(1'b0, '0, 4'hF, 9'd7, c11, 24'h0);
`ifdef SDPRAM_BYPASS_EN
    cyc(1'b1, 9'd7, 4'hF, 9'd7, c22, c22);
`else
    cyc(1'b1, 9'd7, 4'hF, 9'd7, c22, c11);
`endif
    cyc(1'b1, 9'd7, 4'h0, '0, '0, c22);

    cyc(1'b0, '0, 4'hF, 9'd9, c11, 24'h0);
`ifdef SDPRAM_BYPASS_EN
    cyc(1'b1, 9'd9, 4'b0011, 9'd9, c22, m9);
`else
    cyc(1'b1, 9'd9, 4'b0011, 9'd9, c22, c11);
`endif
    cyc(1'b1, 9'd9, 4'h0, '0, '0, m9);

    cyc(1'b0, '0, 4'hF, 9'd20, c22, 24'h0);
    cyc(1'b1, 9'd20, 4'h0, '0, '0, 24'h0);
    cyc(1'b1, 9'd4, 4'h0, '0, '0, 24'h0);

    cyc(1'b1, 9'd5, 4'h0, '0, '0, pk(6'h3F, 6'h2A, 6'h15, 6'h01));
    cyc(1'b1, 9'd3, 4'hF, 9'd2, pk(6'h2A, 6'h2A, 6'h2A, 6'h2A), pk(6'h3F, 6'h00, 6'h3F, 6'h00));
    cyc(1'b1, 9'd2, 4'h0, '0, '0, pk(6'h2A, 6'h2A, 6'h2A, 6'h2A));

    // Reset mid-traffic, then again mid-sweep at address 8
    cyc(1'b1, 9'd2, 4'h0, '0, '0, pk(6'h2A, 6'h2A, 6'h2A, 6'h2A));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rst_dout", 32'(DOUT), 32'd0);
    @(posedge memclk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge memclk); #1;
      chk("partial_sweep_ready", 32'(ready), 32'd0);
    end
    rst = 1'b1;
    @(posedge memclk); #1;
    rst = 1'b0;
    sweep_check(DEP, "restart_sweep_ready");
    cyc(1'b1, 9'd2, 4'h0, '0, '0, 24'h0);
    cyc(1'b1, 9'd5, 4'h0, '0, '0, 24'h0);

    repeat (3) @(posedge memclk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
